// File: rtl/vproc_cfg_unit.sv
// Vector configuration unit: executes vsetvl/vsetvli/vsetivli once the vector
// pipeline has drained, commits vtype/vl and returns the new VL as rd.

package vproc_cfg_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } cfg_vsew;

  typedef enum logic [2:0] {
    LMUL_1       = 3'b000,
    LMUL_2       = 3'b001,
    LMUL_4       = 3'b010,
    LMUL_8       = 3'b011,
    LMUL_INVALID = 3'b100,
    LMUL_F8      = 3'b101,
    LMUL_F4      = 3'b110,
    LMUL_F2      = 3'b111
  } cfg_lmul;

  typedef struct packed {
    cfg_vsew    vsew;
    cfg_lmul    lmul;
    logic [1:0] agnostic;
    logic       vlmax;
    logic       keep_vl;
  } op_mode_cfg;

endpackage

module vproc_cfg_unit
  import vproc_cfg_pkg::*;
#(
  parameter int VREG_W = 128,
  parameter int VL_W   = $clog2(VREG_W) + 1
) (
  input  logic            clk_i,
  input  logic            sync_rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  op_mode_cfg      req_mode_i,
  input  logic [31:0]     req_avl_i,
  input  logic            pipe_idle_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [31:0]     resp_vl_o,
  output cfg_vsew         vsew_o,
  output cfg_lmul         lmul_o,
  output logic [1:0]      agnostic_o,
  output logic            vill_o,
  output logic [VL_W-1:0] vl_o,
  output logic            vl_zero_o,
  output logic            busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      r_state;
  op_mode_cfg      r_mode;
  logic [31:0]     r_avl;
  cfg_vsew         r_vsew;
  cfg_lmul         r_lmul;
  logic [1:0]      r_agnostic;
  logic            r_vill;
  logic [VL_W-1:0] r_vl;
  logic [31:0]     r_resp_vl;

  logic [31:0]     w_vlmax_new;
  logic [31:0]     w_vlmax_cur;
  logic            w_illegal_cfg;
  logic            w_illegal;
  logic [VL_W-1:0] w_new_vl;

  // Integer LMUL scales the register up, fractional LMUL divides it further.
  function automatic logic [31:0] calc_vlmax(input cfg_vsew sew, input cfg_lmul lmul);
    logic [31:0] base;
    logic [2:0]  l;
    base = 32'(VREG_W);
    l    = lmul;
    if (!l[2]) calc_vlmax = (base << l[1:0]) >> (3'd3 + {1'b0, sew});
    else       calc_vlmax = base >> (4'd7 + {2'b00, sew} - {2'b00, l[1:0]});
  endfunction

  assign w_vlmax_new = calc_vlmax(r_mode.vsew, r_mode.lmul);
  assign w_vlmax_cur = calc_vlmax(r_vsew, r_lmul);

  assign w_illegal_cfg = (r_mode.vsew == VSEW_INVALID)
                       || (r_mode.lmul == LMUL_INVALID)
                       || (r_mode.lmul == LMUL_F8)
                       || ((r_mode.lmul == LMUL_F4) && (r_mode.vsew != VSEW_8))
                       || ((r_mode.lmul == LMUL_F2) && (r_mode.vsew == VSEW_32));

  // keep_vl is only meaningful when the old VL still fits the new VLMAX exactly.
  assign w_illegal = w_illegal_cfg
                   || (r_mode.keep_vl && (r_vill || (w_vlmax_new != w_vlmax_cur)));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    w_new_vl = '0;
    if (w_illegal)               w_new_vl = '0;
    else if (r_mode.keep_vl)     w_new_vl = r_vl;
    else if (r_mode.vlmax)       w_new_vl = w_vlmax_new[VL_W-1:0];
    else if (r_avl < w_vlmax_new) w_new_vl = r_avl[VL_W-1:0];
    else                         w_new_vl = w_vlmax_new[VL_W-1:0];
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      r_state    <= S_IDLE;
      r_vsew     <= VSEW_8;
      r_lmul     <= LMUL_1;
      r_agnostic <= 2'b00;
      r_vill     <= 1'b1;
      r_vl       <= '0;
      r_resp_vl  <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (req_valid_i) r_state <= S_DRAIN;
        S_DRAIN: if (pipe_idle_i) r_state <= S_CALC;
        S_CALC: begin
          r_state   <= S_RESP;
          r_vl      <= w_new_vl;
          r_resp_vl <= {{(32-VL_W){1'b0}}, w_new_vl};
          if (w_illegal) begin
            r_vill     <= 1'b1;
            r_vsew     <= VSEW_8;
            r_lmul     <= LMUL_1;
            r_agnostic <= 2'b00;
          end else begin
            r_vill     <= 1'b0;
            r_vsew     <= r_mode.vsew;
            r_lmul     <= r_mode.lmul;
            r_agnostic <= r_mode.agnostic;
          end
        end
        S_RESP:  if (resp_ready_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the request latch needs no reset; it is always loaded before CALC reads it.
  always_ff @(posedge clk_i) begin
    if ((r_state == S_IDLE) && req_valid_i) begin
      r_mode <= req_mode_i;
      r_avl  <= req_avl_i;
    end
  end

  assign req_ready_o  = (r_state == S_IDLE);
  assign resp_valid_o = (r_state == S_RESP);
  assign busy_o       = (r_state != S_IDLE);
  assign resp_vl_o    = r_resp_vl;
  assign vsew_o       = r_vsew;
  assign lmul_o       = r_lmul;
  assign agnostic_o   = r_agnostic;
  assign vill_o       = r_vill;
  assign vl_o         = r_vl;
  assign vl_zero_o    = (r_vl == '0);

endmodule

// File: tb/tb_vproc_cfg_unit.sv
// Self-checking bench for vproc_cfg_unit: a reference model predicts each
// response into a scoreboard queue, popped when the DUT raises resp_valid_o.

module tb_vproc_cfg_unit;
  import vproc_cfg_pkg::*;

  localparam int VREG_W = 128;
  localparam int VL_W   = $clog2(VREG_W) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  op_mode_cfg      req_mode;
  logic [31:0]     req_avl;
  logic            pipe_idle;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_vl;
  cfg_vsew         vsew;
  cfg_lmul         lmul;
  logic [1:0]      agnostic;
  logic            vill;
  logic [VL_W-1:0] vl;
  logic            vl_zero;
  logic            busy;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] vl;
    logic        vill;
    cfg_vsew     vsew;
    cfg_lmul     lmul;
    logic [1:0]  agn;
  } exp_t;

  exp_t sb_q[$];

  // Architectural state as the model believes it is committed.
  logic        m_vill;
  cfg_vsew     m_vsew;
  cfg_lmul     m_lmul;
  logic [1:0]  m_agn;
  logic [31:0] m_vl;

  always #5 clk = ~clk;

  vproc_cfg_unit #(.VREG_W(VREG_W), .VL_W(VL_W)) dut (
    .clk_i        (clk),
    .sync_rst_ni  (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_mode_i   (req_mode),
    .req_avl_i    (req_avl),
    .pipe_idle_i  (pipe_idle),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_vl_o    (resp_vl),
    .vsew_o       (vsew),
    .lmul_o       (lmul),
    .agnostic_o   (agnostic),
    .vill_o       (vill),
    .vl_o         (vl),
    .vl_zero_o    (vl_zero),
    .busy_o       (busy)
  );

  // VLMAX = VREG_W * LMUL / SEW, with LMUL carried in eighths; -1 means illegal.
  function automatic int model_vlmax(input cfg_vsew s, input cfg_lmul l);
    int sew_bits;
    int lmul8;
    case (s)
      VSEW_8:  sew_bits = 8;
      VSEW_16: sew_bits = 16;
      VSEW_32: sew_bits = 32;
      default: return -1;
    endcase
    case (l)
      LMUL_1:  lmul8 = 8;
      LMUL_2:  lmul8 = 16;
      LMUL_4:  lmul8 = 32;
      LMUL_8:  lmul8 = 64;
      LMUL_F4: lmul8 = 2;
      LMUL_F2: lmul8 = 4;
      default: return -1;
    endcase
    if (l == LMUL_F4 && sew_bits > 8) return -1;
    if (l == LMUL_F2 && sew_bits == 32) return -1;
    return (VREG_W * lmul8) / (8 * sew_bits);
  endfunction

  function automatic exp_t model_next(input cfg_vsew s, input cfg_lmul l, input logic [1:0] agn,
                                      input logic vmax, input logic keep, input logic [31:0] avl);
    exp_t e;
    int   nv;
    logic ill;
    nv  = model_vlmax(s, l);
    ill = (nv < 0);
    if (!ill && keep && (m_vill || model_vlmax(m_vsew, m_lmul) != nv)) ill = 1'b1;
    if (ill) begin
      e = '{vl: 32'd0, vill: 1'b1, vsew: VSEW_8, lmul: LMUL_1, agn: 2'b00};
    end else begin
      e = '{vl: 32'd0, vill: 1'b0, vsew: s, lmul: l, agn: agn};
      if (keep)                            e.vl = m_vl;
      else if (vmax)                       e.vl = 32'(nv);
      else if (longint'(avl) < longint'(nv)) e.vl = avl;
      else                                 e.vl = 32'(nv);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_vill = 1'b1; m_vsew = VSEW_8; m_lmul = LMUL_1; m_agn = 2'b00; m_vl = 32'd0;
    sb_q.delete();
  endtask

  // One full operation: stall = DRAIN cycles with pipe_idle low, hold = RESP cycles with resp_ready low.
  task automatic run_op(input string name, input cfg_vsew s, input cfg_lmul l, input logic [1:0] agn,
                        input logic vmax, input logic keep, input logic [31:0] avl,
                        input int stall, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
    else n_pass++;
    sb_q.push_back(model_next(s, l, agn, vmax, keep, avl));
    req_valid = 1'b1;
    req_mode  = '{vsew: s, lmul: l, agnostic: agn, vlmax: vmax, keep_vl: keep};
    req_avl   = avl;
    pipe_idle = (stall == 0);
    @(negedge clk);
    req_valid = $urandom_range(0, 1);
    req_mode  = op_mode_cfg'($urandom);
    req_avl   = $urandom;
    n = 1;
    while (!resp_valid && n < 40) begin
      n_total++;
      if (req_ready !== 1'b0 || busy !== 1'b1 || vill !== m_vill || vsew !== m_vsew ||
          lmul !== m_lmul || agnostic !== m_agn || 32'(vl) !== m_vl)
        $display("FAIL %s in_flight c%0d: ready=%b busy=%b vill=%b vsew=%0d lmul=%0d vl=%0d want ready=0 busy=1 vill=%b vsew=%0d lmul=%0d vl=%0d",
                 name, n, req_ready, busy, vill, vsew, lmul, vl, m_vill, m_vsew, m_lmul, m_vl);
      else n_pass++;
      if (n == stall + 1) pipe_idle = 1'b1;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    n_total++;
    if (!resp_valid) begin
      $display("FAIL %s timeout: no resp_valid after %0d cycles", name, n);
      sb_q.delete();
      return;
    end
    if (n !== 3 + stall) $display("FAIL %s latency: got %0d want %0d", name, n, 3 + stall);
    else n_pass++;
    e = sb_q.pop_front();
    n_total++;
    if (resp_vl !== e.vl || 32'(vl) !== e.vl || vill !== e.vill || vsew !== e.vsew ||
        lmul !== e.lmul || agnostic !== e.agn || vl_zero !== (e.vl == 32'd0))
      $display("FAIL %s result: rd=%0d vl=%0d vill=%b vsew=%0d lmul=%0d agn=%b zero=%b want rd=vl=%0d vill=%b vsew=%0d lmul=%0d agn=%b",
               name, resp_vl, vl, vill, vsew, lmul, agnostic, vl_zero, e.vl, e.vill, e.vsew, e.lmul, e.agn);
    else n_pass++;
    m_vill = e.vill; m_vsew = e.vsew; m_lmul = e.lmul; m_agn = e.agn; m_vl = e.vl;
    pipe_idle = $urandom_range(0, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_total++;
      if (resp_valid !== 1'b1 || resp_vl !== e.vl || req_ready !== 1'b0)
        $display("FAIL %s resp_hold h%0d: valid=%b rd=%0d ready=%b want 1/%0d/0", name, h, resp_valid, resp_vl, req_ready, e.vl);
      else n_pass++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s back_to_idle: valid=%b ready=%b busy=%b want 0/1/0", name, resp_valid, req_ready, busy);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string name);
    n_total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_vl !== 32'd0 || busy !== 1'b0 ||
        vill !== 1'b1 || vsew !== VSEW_8 || lmul !== LMUL_1 || agnostic !== 2'b00 ||
        vl !== '0 || vl_zero !== 1'b1)
      $display("FAIL %s: ready=%b valid=%b rd=%0d busy=%b vill=%b vsew=%0d lmul=%0d agn=%b vl=%0d zero=%b want 1/0/0/0/1/0/0/00/0/1",
               name, req_ready, resp_valid, resp_vl, busy, vill, vsew, lmul, agnostic, vl, vl_zero);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    run_op("e8m1_avl20",   VSEW_8,  LMUL_1,  2'b11, 1'b0, 1'b0, 32'd20, 0, 0);
    run_op("e32m2_avl3",   VSEW_32, LMUL_2,  2'b01, 1'b0, 1'b0, 32'd3,  0, 0);
    run_op("e16f2_vlmax",  VSEW_16, LMUL_F2, 2'b10, 1'b1, 1'b0, 32'd1,  0, 0);
    run_op("e8f4_avlmax",  VSEW_8,  LMUL_F4, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 0);
    run_op("e8m8_avlhigh", VSEW_8,  LMUL_8,  2'b01, 1'b0, 1'b0, 32'h1000_0003, 0, 0);
    run_op("e32m4_avl0",   VSEW_32, LMUL_4,  2'b11, 1'b0, 1'b0, 32'd0,  0, 0);
    run_op("e32m4_avleq",  VSEW_32, LMUL_4,  2'b00, 1'b0, 1'b0, 32'd16, 0, 0);
  endtask

  task automatic test_illegal();
    run_op("e16m8_vlmax",  VSEW_16,      LMUL_8,       2'b11, 1'b1, 1'b0, 32'd0,  0, 0);
    run_op("f8_illegal",   VSEW_8,       LMUL_F8,      2'b11, 1'b1, 1'b0, 32'd9,  0, 0);
    run_op("e32m1_ok",     VSEW_32,      LMUL_1,       2'b10, 1'b0, 1'b0, 32'd7,  0, 0);
    run_op("sew_invalid",  VSEW_INVALID, LMUL_1,       2'b11, 1'b1, 1'b0, 32'd9,  0, 0);
    run_op("lmul_invalid", VSEW_8,       LMUL_INVALID, 2'b01, 1'b0, 1'b0, 32'd9,  0, 0);
    run_op("e16f4_ill",    VSEW_16,      LMUL_F4,      2'b01, 1'b0, 1'b0, 32'd1,  0, 0);
    run_op("e32f2_ill",    VSEW_32,      LMUL_F2,      2'b01, 1'b0, 1'b0, 32'd1,  0, 0);
    run_op("keep_from_vill", VSEW_8,     LMUL_1,       2'b01, 1'b0, 1'b1, 32'd5,  0, 0);
  endtask

  task automatic test_keep_vl();
    run_op("keep_setup", VSEW_8,  LMUL_1, 2'b00, 1'b0, 1'b0, 32'd20, 0, 0);
    run_op("keep_ok",    VSEW_16, LMUL_2, 2'b11, 1'b0, 1'b1, 32'd2,  0, 0);
    run_op("keep_bad",   VSEW_32, LMUL_1, 2'b11, 1'b0, 1'b1, 32'd2,  0, 0);
  endtask

  task automatic test_stall();
    run_op("stall_setup", VSEW_16, LMUL_1, 2'b01, 1'b0, 1'b0, 32'd5,  0, 0);
    run_op("stall_5_3",   VSEW_8,  LMUL_2, 2'b10, 1'b0, 1'b0, 32'd30, 5, 3);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = '{vsew: VSEW_16, lmul: LMUL_2, agnostic: 2'b11, vlmax: 1'b1, keep_vl: 1'b0};
    req_avl   = 32'd5;
    pipe_idle = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pipe_idle = 1'b1;
    model_reset();
    check_reset_outputs("reset_mid_values");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (resp_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL reset_mid_no_resp c%0d: valid=%b busy=%b want 0/0", i, resp_valid, busy);
      else n_pass++;
    end
    run_op("after_reset", VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd20, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      cfg_vsew     s;
      cfg_lmul     l;
      logic [31:0] a;
      s = cfg_vsew'($urandom_range(0, 2));
      l = cfg_lmul'($urandom_range(0, 3));
      a = $urandom_range(0, 200);
      run_op($sformatf("b2b_%0d", i), s, l, 2'($urandom), 1'($urandom), 1'b0, a,
             $urandom_range(0, 2), $urandom_range(0, 1));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_mode   = '{vsew: VSEW_8, lmul: LMUL_1, agnostic: 2'b00, vlmax: 1'b0, keep_vl: 1'b0};
    req_avl    = 32'd0;
    pipe_idle  = 1'b1;
    resp_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_illegal();
    test_keep_vl();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
